bank_cmd_gen: RTL

- Per-bank command generator, directly downstream of the per-bank request queue.
- Consumes one opt_request-shaped request (req_type, data, row, column; bank/bank-group already stripped by the upstream mapper).
- Emits the DRAM command sequence (activate / read_cmd / write_cmd / precharge / refresh_all) to the channel arbiter, tracking the open row and bank timing counters.
- One instance per bank (banks_no = 16 instances).

---
 rtl/bank_cmd_gen_if.sv | 36 +++
 rtl/bank_cmd_gen.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/bank_cmd_gen_if.sv
// Request/command bundle between the per-bank queue, one bank_cmd_gen and the channel arbiter.
// master = the command generator side, slave = the environment (queue, arbiter, refresh timer).
interface bank_cmd_gen_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_WIDTH  = 16,
  parameter int unsigned COL_WIDTH  = 10
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_type;
  logic [DATA_WIDTH-1:0] req_data;
  logic [ROW_WIDTH-1:0]  req_row;
  logic [COL_WIDTH-1:0]  req_col;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [2:0]            cmd;
  logic [ROW_WIDTH-1:0]  cmd_row;
  logic [COL_WIDTH-1:0]  cmd_col;
  logic [DATA_WIDTH-1:0] cmd_data;

  logic                  refresh_req;
  logic                  refresh_ack;
  logic                  row_open;
  logic [ROW_WIDTH-1:0]  open_row;

  modport master (
    input  req_valid, req_type, req_data, req_row, req_col, cmd_ready, refresh_req,
    output req_ready, cmd_valid, cmd, cmd_row, cmd_col, cmd_data, refresh_ack, row_open, open_row
  );

  modport slave (
    output req_valid, req_type, req_data, req_row, req_col, cmd_ready, refresh_req,
    input  req_ready, cmd_valid, cmd, cmd_row, cmd_col, cmd_data, refresh_ack, row_open, open_row
  );
endinterface

// File: rtl/bank_cmd_gen.sv
// Per-bank DRAM command generator: turns one request into PRE/ACT/RD/WR and services refresh.
// Define CLOSED_PAGE_EN to precharge after every read/write (closed-page policy).
module bank_cmd_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ROW_WIDTH  = 16,
  parameter int unsigned COL_WIDTH  = 10,
  parameter int unsigned T_RCD      = 4,
  parameter int unsigned T_RP       = 4,
  parameter int unsigned T_RAS      = 8
) (
  input logic            clk,
  input logic            rst_n,
  bank_cmd_gen_if.master bus
);

  localparam int unsigned TMax0 = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int unsigned TMax  = (TMax0 > T_RAS) ? TMax0 : T_RAS;
  localparam int unsigned CntW  = $clog2(TMax + 1);

  localparam logic [CntW-1:0] RcdLoad = CntW'(T_RCD - 1);
  localparam logic [CntW-1:0] RpLoad  = CntW'(T_RP - 1);
  localparam logic [CntW-1:0] RasLoad = CntW'(T_RAS - 1);

  typedef enum logic [2:0] {StIdle, StPre, StAct, StRdwr, StRef} state_e;

  typedef enum logic [2:0] {
    CmdAct  = 3'd0,
    CmdRd   = 3'd1,
    CmdWr   = 3'd2,
    CmdPre  = 3'd3,
    CmdNone = 3'd4,
    CmdRef  = 3'd5
  } cmd_e;

  state_e                state_q, state_d;
  state_e                after_pre_q, after_pre_d;
  logic                  lat_type_q, lat_type_d;
  logic [DATA_WIDTH-1:0] lat_data_q, lat_data_d;
  logic [ROW_WIDTH-1:0]  lat_row_q, lat_row_d;
  logic [COL_WIDTH-1:0]  lat_col_q, lat_col_d;
  logic                  row_open_q, row_open_d;
  logic [ROW_WIDTH-1:0]  open_row_q, open_row_d;
  logic [CntW-1:0]       rcd_q, rcd_d;
  logic [CntW-1:0]       rp_q, rp_d;
  logic [CntW-1:0]       ras_q, ras_d;

  logic                  req_ready;
  logic                  cmd_valid;
  logic                  cmd_fire;
  cmd_e                  cmd_sel;
  logic [ROW_WIDTH-1:0]  row_sel;
  logic [COL_WIDTH-1:0]  col_sel;
  logic [DATA_WIDTH-1:0] data_sel;
  logic                  refresh_ack;

  // Gated by rst_n so the handshake stays quiet while the bank is held in reset.
  assign req_ready = rst_n & (state_q == StIdle) & ~bus.refresh_req;
  assign cmd_fire  = cmd_valid & bus.cmd_ready;

  always_comb begin
    state_d     = state_q;
    after_pre_d = after_pre_q;
    lat_type_d  = lat_type_q;
    lat_data_d  = lat_data_q;
    lat_row_d   = lat_row_q;
    lat_col_d   = lat_col_q;
    row_open_d  = row_open_q;
    open_row_d  = open_row_q;
    rcd_d       = (rcd_q != '0) ? rcd_q - 1'b1 : '0;
    rp_d        = (rp_q  != '0) ? rp_q  - 1'b1 : '0;
    ras_d       = (ras_q != '0) ? ras_q - 1'b1 : '0;
    cmd_valid   = 1'b0;
    cmd_sel     = CmdNone;
    row_sel     = '0;
    col_sel     = '0;
    data_sel    = '0;
    refresh_ack = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.refresh_req) begin
          if (row_open_q) begin
            state_d     = StPre;
            after_pre_d = StRef;
          end else begin
            state_d = StRef;
          end
        end else if (bus.req_valid) begin
          lat_type_d = bus.req_type;
          lat_data_d = bus.req_data;
          lat_row_d  = bus.req_row;
          lat_col_d  = bus.req_col;
          if (row_open_q && (open_row_q == bus.req_row)) begin
            state_d = StRdwr;
          end else if (row_open_q) begin
            state_d     = StPre;
            after_pre_d = StAct;
          end else begin
            state_d = StAct;
          end
        end
      end

      StPre: begin
        cmd_valid = (ras_q == '0);
        cmd_sel   = CmdPre;
        if (cmd_fire) begin
          row_open_d = 1'b0;
          rp_d       = RpLoad;
          state_d    = after_pre_q;
        end
      end

      StAct: begin
        cmd_valid = (rp_q == '0);
        cmd_sel   = CmdAct;
        row_sel   = lat_row_q;
        if (cmd_fire) begin
          row_open_d = 1'b1;
          open_row_d = lat_row_q;
          rcd_d      = RcdLoad;
          ras_d      = RasLoad;
          state_d    = StRdwr;
        end
      end

      StRdwr: begin
        cmd_valid = (rcd_q == '0);
        cmd_sel   = lat_type_q ? CmdWr : CmdRd;
        row_sel   = lat_row_q;
        col_sel   = lat_col_q;
        data_sel  = lat_type_q ? lat_data_q : '0;
        if (cmd_fire) begin
`ifdef CLOSED_PAGE_EN
          state_d     = StPre;
          after_pre_d = StIdle;
`else
          state_d     = StIdle;
`endif
        end
      end

      StRef: begin
        cmd_valid = (rp_q == '0);
        cmd_sel   = CmdRef;
        if (cmd_fire) begin
          refresh_ack = 1'b1;
          state_d     = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      after_pre_q <= StIdle;
      lat_type_q  <= 1'b0;
      lat_data_q  <= '0;
      lat_row_q   <= '0;
      lat_col_q   <= '0;
      row_open_q  <= 1'b0;
      open_row_q  <= '0;
      rcd_q       <= '0;
      rp_q        <= '0;
      ras_q       <= '0;
    end else begin
      state_q     <= state_d;
      after_pre_q <= after_pre_d;
      lat_type_q  <= lat_type_d;
      lat_data_q  <= lat_data_d;
      lat_row_q   <= lat_row_d;
      lat_col_q   <= lat_col_d;
      row_open_q  <= row_open_d;
      open_row_q  <= open_row_d;
      rcd_q       <= rcd_d;
      rp_q        <= rp_d;
      ras_q       <= ras_d;
    end
  end

  // Command fields are zeroed whenever nothing is offered, so cmd reads none between commands.
  assign bus.req_ready   = req_ready;
  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd         = cmd_valid ? cmd_sel : CmdNone;
  assign bus.cmd_row     = cmd_valid ? row_sel : '0;
  assign bus.cmd_col     = cmd_valid ? col_sel : '0;
  assign bus.cmd_data    = cmd_valid ? data_sel : '0;
  assign bus.refresh_ack = refresh_ack;
  assign bus.row_open    = row_open_q;
  assign bus.open_row    = open_row_q;

endmodule
